cjg_stack_ctrl: RTL and testbench
=================================

# cjg_stack_ctrl

Stack controller that owns the stack pointer and drives the single-port stack memory (`cjg_mem_stack`-style: registered read data, write-on-`push`). It accepts push/pop requests from the CPU core, generates memory address, write strobe and write data, and returns popped data with a valid strobe. It also reports occupancy, full/empty status and overflow/underflow errors.

## Interface
Parameters:
- `WIDTH`, 32, data word width.
- `DEPTH`, 32, number of stack entries; DEPTH ≤ 2**ADDRW.
- `ADDRW`, 5, memory address width.

Ports:
- `clk` in 1: single clock, all logic on rising edge.
- `reset` in 1: synchronous, active-high reset.
- `req_push` in 1: push request; sampled only when `ready`=1.
- `req_pop` in 1: pop request; sampled only when `ready`=1.
- `push_data` in WIDTH: data to push.
- `ready` out 1: controller can accept a request this cycle.
- `pop_valid` out 1: one-cycle strobe; `pop_data` holds popped word.
- `pop_data` out WIDTH: popped word; holds until next pop completes.
- `count` out ADDRW+1: current occupancy, 0..DEPTH.
- `empty` out 1: `count`==0.
- `full` out 1: `count`==DEPTH.
- `overflow` out 1: push rejected because full.
- `underflow` out 1: pop rejected because empty.
- `mem_addr` out ADDRW: memory address, registered.
- `mem_d` out WIDTH: memory write data, registered.
- `mem_push` out 1: memory write strobe, registered, one cycle.
- `mem_pop` out 1: memory read-cycle marker, registered, one cycle.
- `mem_q` in WIDTH: memory read data, valid one cycle after `mem_addr` is sampled.

## Operation
- States: IDLE, RD, CAP. `ready`=1 only in IDLE.
- Accepted push (IDLE, `req_push`=1, not full): `mem_addr`<=`count`, `mem_d`<=`push_data`, `mem_push`<=1, `count`<=`count`+1; state stays IDLE.
- Accepted pop (IDLE, `req_pop`=1, `req_push`=0, not empty): `mem_addr`<=`count`-1, `mem_pop`<=1, `count`<=`count`-1, state<=RD.
- RD: memory samples `mem_addr`. `mem_pop`<=0. Next state CAP.
- CAP: `pop_data`<=`mem_q`, `pop_valid`<=1. Next state IDLE.
- `req_push` and `req_pop` both high: push takes priority and the pop is dropped silently. A full stack in this case raises `overflow`.
- Push when full: no memory write, `count` unchanged, `overflow` asserted.
- Pop when empty: no state change, no `pop_valid`, `underflow` asserted.
- `mem_push`, `mem_pop` and `pop_valid` deassert on the cycle after they are asserted, unless a new push is accepted back-to-back.
- `mem_addr` and `mem_d` hold their last value when idle.
- Address arithmetic is ADDRW bits, truncated from `count`. `count` never exceeds DEPTH and never goes below 0.

## Timing
- Reset (synchronous, has priority over everything, including mid-pop in RD or CAP): state IDLE, `count`=0, `empty`=1, `full`=0, `ready`=1.
- Reset also clears all other outputs: `pop_valid`, `pop_data`, `mem_addr`, `mem_d`, `mem_push`, `mem_pop`, `overflow` and `underflow` are all 0. An in-flight pop is abandoned.
- Push accepted at edge N: `mem_push`=1 in cycle N..N+1, and memory writes at edge N+1. Throughput is one push per cycle.
- Pop accepted at edge N: RD in N..N+1, CAP in N+1..N+2, and `pop_valid`=1 in N+2..N+3. `ready`=0 in N..N+2, so the next request is accepted at edge N+3.
- Pop immediately after a push (edges N, N+1) returns the just-pushed word.
- `count`, `empty` and `full` update on the accepting edge.

## Configuration
- `CJG_STACK_ERR_STICKY_EN` defined: `overflow`/`underflow` are sticky and stay set until reset.
- Not defined: `overflow`/`underflow` are one-cycle pulses on the cycle after the rejected request.
- All other behaviour is identical in both builds.

## Test plan
- Reset, then idle -> `count`=0, `empty`=1, `ready`=1, and all strobes 0.
- DEPTH=4: push 0x11, 0x22, 0x33, 0x44 on consecutive cycles -> `mem_addr` 0,1,2,3 with `mem_push`=1 each cycle; `full`=1 and `count`=4.
- Continue from the full stack and pop four times -> `pop_data` 0x44, 0x33, 0x22, 0x11. Each `pop_valid` comes 2 cycles after acceptance, and pops are spaced 3 cycles apart. Ends with `empty`=1.
- Push 0xA5 then pop on the next cycle -> `pop_data`=0xA5 and `count` returns to 0.
- Pop on an empty stack and push on a full stack -> `underflow`/`overflow` set, with no `mem_push` and no `pop_valid`. Run in both builds: pulses without `CJG_STACK_ERR_STICKY_EN`, held until reset with it.
- Simultaneous `req_push`+`req_pop` with 0x5A, then assert `reset` during RD of a later pop -> the push of 0x5A occurs and the pop is ignored; after reset, `count`=0 and `pop_valid` never asserts.

Source files
------------

// File: rtl/cjg_stack_ctrl.sv
// cjg_stack_ctrl: owns the stack pointer and sequences push/pop on a single-port stack memory.
// Build option CJG_STACK_ERR_STICKY_EN: overflow/underflow latch until reset instead of pulsing.
module cjg_stack_ctrl #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int ADDRW = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_push,
  input  logic             req_pop,
  input  logic [WIDTH-1:0] push_data,
  output logic             ready,
  output logic             pop_valid,
  output logic [WIDTH-1:0] pop_data,
  output logic [ADDRW:0]   count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow,
  output logic [ADDRW-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_d,
  output logic             mem_push,
  output logic             mem_pop,
  input  logic [WIDTH-1:0] mem_q
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    CAP  = 2'd2
  } state_e;

  localparam logic [ADDRW:0] DEPTH_C = (ADDRW + 1)'(DEPTH);
  localparam logic [ADDRW:0] ONE_C   = (ADDRW + 1)'(1);

  state_e           state_q;
  logic [ADDRW:0]   count_q;
  logic             pop_valid_q;
  logic [WIDTH-1:0] pop_data_q;
  logic [ADDRW-1:0] mem_addr_q;
  logic [WIDTH-1:0] mem_d_q;
  logic             mem_push_q;
  logic             mem_pop_q;
  logic             overflow_q;
  logic             underflow_q;
  logic             overflow_d;
  logic             underflow_d;

  logic             idle_s;
  logic             full_s;
  logic             empty_s;
  logic             push_acc_s;
  logic             pop_acc_s;
  logic             ovf_evt_s;
  logic             unf_evt_s;
  logic [ADDRW:0]   count_dec_s;

  assign idle_s      = (state_q == IDLE);
  assign full_s      = (count_q == DEPTH_C);
  assign empty_s     = (count_q == {(ADDRW + 1){1'b0}});
  assign count_dec_s = count_q - ONE_C;

  // A simultaneous push wins; the pop is dropped and never counts as an underflow.
  assign push_acc_s = idle_s && req_push && !full_s;
  assign pop_acc_s  = idle_s && req_pop && !req_push && !empty_s;
  assign ovf_evt_s  = idle_s && req_push && full_s;
  assign unf_evt_s  = idle_s && req_pop && !req_push && empty_s;

  // Error flag next-state: latched or single-cycle depending on build.
  always_comb begin
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
`ifdef CJG_STACK_ERR_STICKY_EN
    overflow_d  = overflow_q | ovf_evt_s;
    underflow_d = underflow_q | unf_evt_s;
`else
    overflow_d  = ovf_evt_s;
    underflow_d = unf_evt_s;
`endif
  end

  // Controller FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      count_q     <= {(ADDRW + 1){1'b0}};
      pop_valid_q <= 1'b0;
      pop_data_q  <= {WIDTH{1'b0}};
      mem_addr_q  <= {ADDRW{1'b0}};
      mem_d_q     <= {WIDTH{1'b0}};
      mem_push_q  <= 1'b0;
      mem_pop_q   <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      mem_push_q  <= 1'b0;
      mem_pop_q   <= 1'b0;
      pop_valid_q <= 1'b0;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      case (state_q)
        IDLE: begin
          if (push_acc_s) begin
            mem_addr_q <= count_q[ADDRW-1:0];
            mem_d_q    <= push_data;
            mem_push_q <= 1'b1;
            count_q    <= count_q + ONE_C;
          end else if (pop_acc_s) begin
            mem_addr_q <= count_dec_s[ADDRW-1:0];
            mem_pop_q  <= 1'b1;
            count_q    <= count_dec_s;
            state_q    <= RD;
          end
        end
        RD: begin
          state_q <= CAP;
        end
        CAP: begin
          pop_data_q  <= mem_q;
          pop_valid_q <= 1'b1;
          state_q     <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ready     = idle_s;
  assign count     = count_q;
  assign empty     = empty_s;
  assign full      = full_s;
  assign pop_valid = pop_valid_q;
  assign pop_data  = pop_data_q;
  assign mem_addr  = mem_addr_q;
  assign mem_d     = mem_d_q;
  assign mem_push  = mem_push_q;
  assign mem_pop   = mem_pop_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_cjg_stack_ctrl.sv
// Directed bench for cjg_stack_ctrl (WIDTH=8, DEPTH=4, ADDRW=2) with a registered-read stack memory model.
// Build with +define+CJG_STACK_ERR_STICKY_EN to check the sticky error variant.
module tb_cjg_stack_ctrl;

`ifdef CJG_STACK_ERR_STICKY_EN
  localparam logic STICKY = 1'b1;
`else
  localparam logic STICKY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       req_push;
  logic       req_pop;
  logic [7:0] push_data;
  logic       ready;
  logic       pop_valid;
  logic [7:0] pop_data;
  logic [2:0] count;
  logic       empty;
  logic       full;
  logic       overflow;
  logic       underflow;
  logic [1:0] mem_addr;
  logic [7:0] mem_d;
  logic       mem_push;
  logic       mem_pop;
  logic [7:0] mem_q;

  int n_checks = 0;
  int n_pass   = 0;

  cjg_stack_ctrl #(.WIDTH(8), .DEPTH(4), .ADDRW(2)) dut (
    .clk(clk), .reset(reset), .req_push(req_push), .req_pop(req_pop),
    .push_data(push_data), .ready(ready), .pop_valid(pop_valid), .pop_data(pop_data),
    .count(count), .empty(empty), .full(full), .overflow(overflow), .underflow(underflow),
    .mem_addr(mem_addr), .mem_d(mem_d), .mem_push(mem_push), .mem_pop(mem_pop), .mem_q(mem_q)
  );

  always #5 clk = ~clk;

  // Single-port stack memory: write on mem_push, registered read every cycle.
  logic [7:0] mem [4];
  initial begin
    for (int i = 0; i < 4; i++) mem[i] = 8'h00;
    mem_q = 8'h00;
  end
  always @(posedge clk) begin
    if (mem_push) mem[mem_addr] <= mem_d;
    mem_q <= mem[mem_addr];
  end

  typedef struct {
    logic       push;
    logic       pop;
    logic [7:0] din;
    logic       rdy;
    logic [2:0] cnt;
    logic       emp;
    logic       ful;
    logic       mp;
    logic       mpop;
    logic [1:0] maddr;
    logic [7:0] md;
    logic       pv;
    logic [7:0] pd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic push, logic pop, logic [7:0] din, logic rdy, logic [2:0] cnt,
                              logic emp, logic ful, logic mp, logic mpop, logic [1:0] maddr,
                              logic [7:0] md, logic pv, logic [7:0] pd);
    vec_t v;
    v.push = push; v.pop = pop; v.din = din; v.rdy = rdy; v.cnt = cnt; v.emp = emp;
    v.ful = ful; v.mp = mp; v.mpop = mpop; v.maddr = maddr; v.md = md; v.pv = pv; v.pd = pd;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic check_outs(string tag, vec_t e, logic eo, logic eu);
    chk({tag, " ready"},     32'(ready),     32'(e.rdy));
    chk({tag, " count"},     32'(count),     32'(e.cnt));
    chk({tag, " empty"},     32'(empty),     32'(e.emp));
    chk({tag, " full"},      32'(full),      32'(e.ful));
    chk({tag, " mem_push"},  32'(mem_push),  32'(e.mp));
    chk({tag, " mem_pop"},   32'(mem_pop),   32'(e.mpop));
    chk({tag, " mem_addr"},  32'(mem_addr),  32'(e.maddr));
    chk({tag, " mem_d"},     32'(mem_d),     32'(e.md));
    chk({tag, " pop_valid"}, 32'(pop_valid), 32'(e.pv));
    chk({tag, " pop_data"},  32'(pop_data),  32'(e.pd));
    chk({tag, " overflow"},  32'(overflow),  32'(eo));
    chk({tag, " underflow"}, 32'(underflow), 32'(eu));
  endtask

  task automatic step(logic p, logic o, logic [7:0] d, logic r);
    req_push  = p;
    req_pop   = o;
    push_data = d;
    reset     = r;
    @(posedge clk);
    #1;
  endtask

  vec_t rst_v;

  initial begin
    //          push pop din   rdy cnt  emp ful mp mpop maddr md     pv pd
    vecs.push_back(mk(0, 0, 8'h00, 1, 3'd0, 1, 0, 0, 0, 2'd0, 8'h00, 0, 8'h00));
    vecs.push_back(mk(1, 0, 8'h11, 1, 3'd1, 0, 0, 1, 0, 2'd0, 8'h11, 0, 8'h00));
    vecs.push_back(mk(1, 0, 8'h22, 1, 3'd2, 0, 0, 1, 0, 2'd1, 8'h22, 0, 8'h00));
    vecs.push_back(mk(1, 0, 8'h33, 1, 3'd3, 0, 0, 1, 0, 2'd2, 8'h33, 0, 8'h00));
    vecs.push_back(mk(1, 0, 8'h44, 1, 3'd4, 0, 1, 1, 0, 2'd3, 8'h44, 0, 8'h00));
    vecs.push_back(mk(0, 1, 8'h00, 0, 3'd3, 0, 0, 0, 1, 2'd3, 8'h44, 0, 8'h00));
    vecs.push_back(mk(0, 0, 8'h00, 0, 3'd3, 0, 0, 0, 0, 2'd3, 8'h44, 0, 8'h00));
    vecs.push_back(mk(0, 0, 8'h00, 1, 3'd3, 0, 0, 0, 0, 2'd3, 8'h44, 1, 8'h44));
    vecs.push_back(mk(0, 1, 8'h00, 0, 3'd2, 0, 0, 0, 1, 2'd2, 8'h44, 0, 8'h44));
    vecs.push_back(mk(0, 0, 8'h00, 0, 3'd2, 0, 0, 0, 0, 2'd2, 8'h44, 0, 8'h44));
    vecs.push_back(mk(0, 0, 8'h00, 1, 3'd2, 0, 0, 0, 0, 2'd2, 8'h44, 1, 8'h33));
    vecs.push_back(mk(0, 1, 8'h00, 0, 3'd1, 0, 0, 0, 1, 2'd1, 8'h44, 0, 8'h33));
    vecs.push_back(mk(0, 0, 8'h00, 0, 3'd1, 0, 0, 0, 0, 2'd1, 8'h44, 0, 8'h33));
    vecs.push_back(mk(0, 0, 8'h00, 1, 3'd1, 0, 0, 0, 0, 2'd1, 8'h44, 1, 8'h22));
    vecs.push_back(mk(0, 1, 8'h00, 0, 3'd0, 1, 0, 0, 1, 2'd0, 8'h44, 0, 8'h22));
    vecs.push_back(mk(0, 0, 8'h00, 0, 3'd0, 1, 0, 0, 0, 2'd0, 8'h44, 0, 8'h22));
    vecs.push_back(mk(0, 0, 8'h00, 1, 3'd0, 1, 0, 0, 0, 2'd0, 8'h44, 1, 8'h11));
    // push then pop on the next cycle returns the just-pushed word
    vecs.push_back(mk(1, 0, 8'hA5, 1, 3'd1, 0, 0, 1, 0, 2'd0, 8'hA5, 0, 8'h11));
    vecs.push_back(mk(0, 1, 8'h00, 0, 3'd0, 1, 0, 0, 1, 2'd0, 8'hA5, 0, 8'h11));
    // push offered while busy is ignored
    vecs.push_back(mk(1, 0, 8'h77, 0, 3'd0, 1, 0, 0, 0, 2'd0, 8'hA5, 0, 8'h11));
    vecs.push_back(mk(0, 0, 8'h00, 1, 3'd0, 1, 0, 0, 0, 2'd0, 8'hA5, 1, 8'hA5));

    rst_v = mk(0, 0, 8'h00, 1, 3'd0, 1, 0, 0, 0, 2'd0, 8'h00, 0, 8'h00);

    step(0, 0, 8'h00, 1);
    step(0, 0, 8'h00, 1);
    check_outs("reset", rst_v, 1'b0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].push, vecs[i].pop, vecs[i].din, 1'b0);
      check_outs($sformatf("vec%0d", i), vecs[i], 1'b0, 1'b0);
    end

    // underflow on empty stack
    step(0, 1, 8'h00, 0);
    check_outs("unf", mk(0, 0, 8'h00, 1, 3'd0, 1, 0, 0, 0, 2'd0, 8'hA5, 0, 8'hA5), 1'b0, 1'b1);
    step(0, 0, 8'h00, 0);
    check_outs("unf_after", mk(0, 0, 8'h00, 1, 3'd0, 1, 0, 0, 0, 2'd0, 8'hA5, 0, 8'hA5), 1'b0, STICKY);

    // fill, then overflow on full stack
    for (int i = 1; i <= 4; i++) step(1, 0, 8'(i), 0);
    check_outs("fill", mk(0, 0, 8'h00, 1, 3'd4, 0, 1, 1, 0, 2'd3, 8'h04, 0, 8'hA5), 1'b0, STICKY);
    step(1, 1, 8'h99, 0);
    check_outs("ovf", mk(0, 0, 8'h00, 1, 3'd4, 0, 1, 0, 0, 2'd3, 8'h04, 0, 8'hA5), 1'b1, STICKY);
    step(0, 0, 8'h00, 0);
    check_outs("ovf_after", mk(0, 0, 8'h00, 1, 3'd4, 0, 1, 0, 0, 2'd3, 8'h04, 0, 8'hA5), STICKY, STICKY);
    chk("mem_top_kept", 32'(mem[3]), 32'h04);

    step(0, 0, 8'h00, 1);
    check_outs("reset2", rst_v, 1'b0, 1'b0);

    // simultaneous push+pop: push wins
    step(1, 1, 8'h5A, 0);
    check_outs("pushpop", mk(0, 0, 8'h00, 1, 3'd1, 0, 0, 1, 0, 2'd0, 8'h5A, 0, 8'h00), 1'b0, 1'b0);
    step(0, 1, 8'h00, 0);
    check_outs("pop_acc", mk(0, 0, 8'h00, 0, 3'd0, 1, 0, 0, 1, 2'd0, 8'h5A, 0, 8'h00), 1'b0, 1'b0);
    // reset while in RD abandons the pop
    step(0, 0, 8'h00, 1);
    check_outs("reset_rd", rst_v, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 8'h00, 0);
      check_outs($sformatf("post_rst%0d", i), rst_v, 1'b0, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
